// File: rtl/rram_uart_tx64_if.sv
// Handshake bundle between the RRAM controller (master) and the 64-bit UART transmitter (slave).
interface rram_uart_tx64_if;
    logic        tx_en;
    logic [63:0] tx_reg;
    logic        tx_dv;
    logic        tx_serial;
    logic        tx_done;

    modport master (
        output tx_en,
        output tx_reg,
        input  tx_dv,
        input  tx_serial,
        input  tx_done
    );

    modport slave (
        input  tx_en,
        input  tx_reg,
        output tx_dv,
        output tx_serial,
        output tx_done
    );
endinterface

// File: rtl/rram_uart_tx64.sv
// Sends a 64-bit word as eight UART frames, MSB byte first, each byte LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1); default build is 8N1.
module rram_uart_tx64 #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst_n,
    rram_uart_tx64_if.slave  bus
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [2:0]    state_r;
    logic [63:0]   shreg_r;
    logic [2:0]    byte_idx_r;
    logic [2:0]    bit_idx_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          serial_r;
    logic          done_r;

    logic [7:0]    cur_byte_s;
    logic          bit_end_s;
    logic          next_bit_s;

    assign cur_byte_s = shreg_r[63:56];
    assign bit_end_s  = (cnt_r == CNT_LAST);
    assign next_bit_s = cur_byte_s[bit_idx_r + 3'd1];

    // Controller must see busy in the very cycle it raises the strobe.
    assign bus.tx_dv     = busy_r | bus.tx_en;
    assign bus.tx_serial = serial_r;
    assign bus.tx_done   = done_r;

    // Frame sequencer: the line level for each bit is registered on the edge that enters it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shreg_r    <= 64'd0;
            byte_idx_r <= 3'd0;
            bit_idx_r  <= 3'd0;
            cnt_r      <= CNT_ZERO;
            busy_r     <= 1'b0;
            serial_r   <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    serial_r <= 1'b1;
                    cnt_r    <= CNT_ZERO;
                    if (bus.tx_en) begin
                        shreg_r    <= bus.tx_reg;
                        byte_idx_r <= 3'd0;
                        busy_r     <= 1'b1;
                        serial_r   <= 1'b0;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cnt_r     <= CNT_ZERO;
                        bit_idx_r <= 3'd0;
                        serial_r  <= cur_byte_s[0];
                        state_r   <= ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= CNT_ZERO;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            serial_r <= even_parity(cur_byte_s);
                            state_r  <= ST_PARITY;
`else
                            serial_r <= 1'b1;
                            state_r  <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            serial_r  <= next_bit_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        cnt_r    <= CNT_ZERO;
                        serial_r <= 1'b1;
                        state_r  <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= CNT_ZERO;
                        if (byte_idx_r != 3'd7) begin
                            shreg_r    <= {shreg_r[55:0], 8'h00};
                            byte_idx_r <= byte_idx_r + 3'd1;
                            serial_r   <= 1'b0;
                            state_r    <= ST_START;
                        end else begin
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            serial_r <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= CNT_ZERO;
                    busy_r   <= 1'b0;
                    serial_r <= 1'b1;
                end
            endcase
        end
    end

endmodule
